mips_mem_arbiter: RTL and testbench
===================================

# mips_mem_arbiter

Sequencer and two-port arbiter in front of the single-ported byte-addressed data memory (read captured on posedge, write committed on negedge). Shares the memory between the instruction-fetch port (word reads only) and the data port (byte/half/word reads and writes). Sequences each access through a fixed 3-state FSM, range-checks addresses against the memory size and guarantees fetch forward progress under data-port saturation.

## Interface
- MEM_BYTES, 501: memory size in bytes; valid byte addresses 0..MEM_BYTES-1
- STARVE_LIMIT, 4: consecutive data-port grants while fetch is pending before fetch is forced to win
- clk  in  1  single clock; all state on posedge
- reset_n  in  1  synchronous, active-low reset (sampled on posedge clk)
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  17  fetch byte address (always a 4-byte read)
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  32  fetch data, valid while if_ack
- if_err  out  1  range error, valid while if_ack
- dm_req  in  1  data request; held with dm_we/dm_size/dm_addr/dm_wdata until dm_ack
- dm_we  in  1  1 = write, 0 = read
- dm_size  in  2  00 byte, 01 half, 10/11 word
- dm_addr  in  17  data byte address
- dm_wdata  in  32  write data (low bytes used for byte/half)
- dm_ack, dm_rdata[31:0], dm_err  out  as fetch port
- mem_address  out  17  to memory
- mem_data_in  out  32  to memory
- mem_data_out  in  32  from memory (zero-extended by memory for byte/half)
- mem_read_enable, mem_write_enable  out  1  to memory
- mem_write_size  out  2  to memory (fetch always drives 2'b10)

## Operation
- FSM states IDLE, ACCESS, DONE; reset state IDLE.
- IDLE: no request -> stay. Request(s) present -> pick winner, register owner, mem_address, mem_data_in, mem_write_size; range-check.
  - In range -> ACCESS, assert mem_read_enable (read) or mem_write_enable (write).
  - Out of range -> DONE directly, no memory enable, err flag set.
- Range rule: nbytes = 1/2/4 per size; error iff addr + nbytes - 1 > MEM_BYTES-1, computed at 18 bits (no wrap).
- ACCESS: exactly one cycle; enables drop at exit; -> DONE.
- DONE: owner's ack = 1 (combinational from state/owner); rdata = mem_data_out for in-range reads, 0 for writes and errors; err = registered flag. Non-owner ack/err/rdata = 0. -> IDLE unconditionally (requests ignored this cycle).
- Arbitration: data port beats fetch, except when starve counter == STARVE_LIMIT and if_req is high, then fetch wins.
- Starve counter: +1 per data grant made while if_req high (saturates at STARVE_LIMIT); cleared on fetch grant or on any IDLE cycle with if_req low.
- mem_address/mem_data_in/mem_write_size hold last value outside ACCESS.

## Timing
- Request sampled at posedge E0 (IDLE) -> ACCESS cycle -> ack in DONE cycle: ack visible 2 cycles after grant sample; one transaction per 3 cycles max.
- Write commits at the negedge inside ACCESS; read data captured by memory at posedge ending ACCESS, valid throughout DONE.
- Out-of-range: ack 1 cycle after grant sample.
- Reset values: state IDLE, all acks/errs 0, rdata 0, mem enables 0, mem_address 0, mem_data_in 0, mem_write_size 0, counter 0, owner = fetch.
- Reset during ACCESS: write already committed at that negedge stands; read discarded, no ack. Reset during DONE: ack drops next cycle, no replay.
- Simultaneous if_req/dm_req in IDLE: priority rule above; loser stays pending, served after DONE.
- Requester dropping req before ack: protocol violation, behaviour undefined (bench asserts it).

## Structure
- Package mips_mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, owner enum, default MEM_BYTES.
- One sub-module natural: mips_mem_range_check (addr, size, MEM_BYTES -> err), used once on winner's muxed request.

## Test plan
- Fetch read addr 0x10 after writing word 0xDEADBEEF there -> if_ack 2 cycles after sample, if_rdata 0xDEADBEEF, if_err 0.
- Data byte write 0xA5 to 0x21, half read at 0x20 -> dm_rdata 0x0000A5xx with untouched low byte preserved; byte read 0x21 -> 0x000000A5.
- Both ports requesting continuously, STARVE_LIMIT=4 -> grant sequence D,D,D,D,F,D,D,D,D,F; each ack 3 cycles apart.
- Word read at addr 498 -> dm_ack 1 cycle after sample, dm_err 1, dm_rdata 0, mem enables never high; word read at 497 -> no error.
- Word write at 496 with reset_n low at posedge ending ACCESS -> memory holds data, no dm_ack, all outputs at reset values next cycle.
- Byte write at 500 -> ok; byte write at 501 -> dm_err 1, memory unchanged.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory arbiter.
// Size codes, FSM states, port owner and defaults.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MEM_BYTES_DEF = 501;
  localparam int STARVE_DEF    = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_e;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    logic [2:0] n;
    n = 3'd4;
    unique case (1'b1)
      sz == SZ_BYTE: n = 3'd1;
      sz == SZ_HALF: n = 3'd2;
      sz[1]:         n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mips_mem_range_check.sv
// Flags accesses whose last byte falls past
// the end of memory; no wrap at 17 bits.
module mips_mem_range_check
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic [16:0] addr,
  input  logic [1:0]  size,
  output logic        err
);

  localparam logic [17:0] LAST_OK =
    18'(MEM_BYTES - 1);

  logic [17:0] last;

  always_comb begin
    last = {1'b0, addr}
         + {15'd0, size_bytes(size)}
         - 18'd1;
    err  = last > LAST_OK;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Fetch/data arbiter and 3-state sequencer
// in front of the single-ported data memory.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES    = MEM_BYTES_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [16:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [16:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic [16:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [1:0]  mem_write_size
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM =
    CW'(STARVE_LIMIT);

  state_e        state_q, state_d;
  owner_e        own_q, own_d;
  logic [16:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    wsize_q, wsize_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic          rdok_q, rdok_d;
  logic [CW-1:0] starve_q, starve_d;

  logic          pick_if;
  logic [16:0]   w_addr;
  logic [1:0]    w_size;
  logic          w_we;
  logic          w_err;
  logic          done;

  always_comb begin
    pick_if = if_req
            & (~dm_req | (starve_q == LIM));
    w_addr  = pick_if ? if_addr : dm_addr;
    w_size  = pick_if ? SZ_WORD : dm_size;
    w_we    = ~pick_if & dm_we;
  end

  mips_mem_range_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_range (
    .addr (w_addr),
    .size (w_size),
    .err  (w_err)
  );

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wsize_d  = wsize_q;
    re_d     = re_q;
    we_d     = we_q;
    err_d    = err_q;
    rdok_d   = rdok_q;
    starve_d = starve_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!if_req) starve_d = '0;
        if (if_req || dm_req) begin
          own_d   = pick_if ? OWN_IF : OWN_DM;
          addr_d  = w_addr;
          wsize_d = w_size;
          if (!pick_if) wdata_d = dm_wdata;
          err_d   = w_err;
          rdok_d  = ~w_we & ~w_err;
          re_d    = ~w_we & ~w_err;
          we_d    = w_we & ~w_err;
          state_d = w_err ? ST_DONE
                          : ST_ACCESS;
          if (pick_if)
            starve_d = '0;
          else if (if_req && starve_q != LIM)
            starve_d = starve_q + CW'(1);
        end
      end
      ST_ACCESS: begin
        re_d    = 1'b0;
        we_d    = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      own_q    <= OWN_IF;
      addr_q   <= '0;
      wdata_q  <= '0;
      wsize_q  <= '0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rdok_q   <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wsize_q  <= wsize_d;
      re_q     <= re_d;
      we_q     <= we_d;
      err_q    <= err_d;
      rdok_q   <= rdok_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    done     = state_q == ST_DONE;
    if_ack   = done & (own_q == OWN_IF);
    dm_ack   = done & (own_q == OWN_DM);
    if_err   = if_ack & err_q;
    dm_err   = dm_ack & err_q;
    if_rdata = (if_ack & rdok_q)
             ? mem_data_out : '0;
    dm_rdata = (dm_ack & rdok_q)
             ? mem_data_out : '0;
    mem_address      = addr_q;
    mem_data_in      = wdata_q;
    mem_write_size   = wsize_q;
    mem_read_enable  = re_q;
    mem_write_enable = we_q;
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter with
// a byte-array memory model behind it.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int MB = 501;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [16:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [16:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic [16:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [1:0]  mem_write_size;

  always #5 clk = ~clk;

  mips_mem_arbiter #(
    .MEM_BYTES    (MB),
    .STARVE_LIMIT (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_ack           (if_ack),
    .if_rdata         (if_rdata),
    .if_err           (if_err),
    .dm_req           (dm_req),
    .dm_we            (dm_we),
    .dm_size          (dm_size),
    .dm_addr          (dm_addr),
    .dm_wdata         (dm_wdata),
    .dm_ack           (dm_ack),
    .dm_rdata         (dm_rdata),
    .dm_err           (dm_err),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_size   (mem_write_size)
  );

  typedef struct {
    bit          dm;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  bit   if_p = 1'b0;
  bit   dm_p = 1'b0;
  bit   mem_init = 1'b0;
  logic [7:0] mem [0:MB-1];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nb(logic [1:0] s);
    return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
  endfunction

  function automatic logic [31:0] rd(
    logic [16:0] a, logic [1:0] s
  );
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      if (k < nb(s) && int'(a) + k < MB)
        r[8*k +: 8] = mem[int'(a) + k];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < MB; i++)
        mem[i] <= 8'(i);
      mem_init <= 1'b1;
    end else if (mem_write_enable) begin
      for (int k = 0; k < 4; k++)
        if (k < nb(mem_write_size)
            && int'(mem_address) + k < MB)
          mem[int'(mem_address) + k]
            <= mem_data_in[8*k +: 8];
    end
  end

  always @(posedge clk)
    if (mem_read_enable)
      mem_data_out <=
        rd(mem_address, mem_write_size);

  task automatic chk(
    string nm, logic [31:0] act,
    logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic flag(string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  task automatic push(
    bit dm, logic [31:0] r, bit err, int at
  );
    exp_t e;
    e.dm = dm;
    e.rdata = r;
    e.err = err;
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic mon_step();
    exp_t e;
    if (mem_read_enable || mem_write_enable)
      en_cnt++;
    if (reset_n && if_p && !if_req && !if_ack)
      flag("if_req dropped before ack");
    if (reset_n && dm_p && !dm_req && !dm_ack)
      flag("dm_req dropped before ack");
    if_p = if_req;
    dm_p = dm_req;
    if (if_ack || dm_ack) begin
      if (q.size() == 0) begin
        flag("unexpected ack");
      end else begin
        e = q.pop_front();
        chk("ack port dm", 32'(dm_ack),
            32'(e.dm));
        chk(e.dm ? "dm_rdata" : "if_rdata",
            e.dm ? dm_rdata : if_rdata,
            e.rdata);
        chk(e.dm ? "dm_err" : "if_err",
            32'(e.dm ? dm_err : if_err),
            32'(e.err));
        chk("ack cycle", 32'(cyc),
            32'(e.cyc));
        chk("other port ack/err",
            e.dm ? 32'({if_ack, if_err})
                 : 32'({dm_ack, dm_err}),
            32'd0);
        chk("other port rdata",
            e.dm ? if_rdata : dm_rdata,
            32'd0);
      end
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, " acks/errs/enables"},
        32'({if_ack, if_err, dm_ack, dm_err,
             mem_read_enable,
             mem_write_enable}), 32'd0);
    chk({tag, " if_rdata"}, if_rdata, 32'd0);
    chk({tag, " dm_rdata"}, dm_rdata, 32'd0);
    chk({tag, " mem_address"},
        32'(mem_address), 32'd0);
    chk({tag, " mem_data_in"},
        mem_data_in, 32'd0);
    chk({tag, " mem_write_size"},
        32'(mem_write_size), 32'd0);
  endtask

  task automatic dm_txn(
    bit we, logic [1:0] sz, logic [16:0] a,
    logic [31:0] wd, logic [31:0] er, bit ee
  );
    int c;
    bit got;
    @(posedge clk);
    #1;
    c = cyc;
    push(1'b1, er, ee, c + (ee ? 1 : 2));
    dm_req = 1'b1;
    dm_we = we;
    dm_size = sz;
    dm_addr = a;
    dm_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      got = dm_ack;
    end
    if (!got) flag("dm ack timeout");
    dm_req = 1'b0;
  endtask

  task automatic if_txn(
    logic [16:0] a, logic [31:0] er, bit ee
  );
    int c;
    bit got;
    @(posedge clk);
    #1;
    c = cyc;
    push(1'b0, er, ee, c + (ee ? 1 : 2));
    if_req = 1'b1;
    if_addr = a;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      got = if_ack;
    end
    if (!got) flag("if ack timeout");
    if_req = 1'b0;
  endtask

  task automatic starve_test();
    int c;
    bit d;
    @(posedge clk);
    #1;
    c = cyc;
    for (int k = 0; k < 10; k++) begin
      d = !(k == 4 || k == 9);
      push(d, d ? 32'h0000_00A5
                : 32'hDEAD_BEEF,
           1'b0, c + 2 + 3 * k);
    end
    if_req = 1'b1;
    if_addr = 17'h10;
    dm_req = 1'b1;
    dm_we = 1'b0;
    dm_size = SZ_BYTE;
    dm_addr = 17'h21;
    while (cyc < c + 26) begin
      @(posedge clk);
      #1;
    end
    dm_req = 1'b0;
    while (cyc < c + 29) begin
      @(posedge clk);
      #1;
    end
    if_req = 1'b0;
    repeat (3) @(posedge clk);
    chk("starve queue drained",
        32'(q.size()), 32'd0);
  endtask

  task automatic reset_in_access();
    @(posedge clk);
    #1;
    dm_req = 1'b1;
    dm_we = 1'b1;
    dm_size = SZ_WORD;
    dm_addr = 17'd496;
    dm_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    dm_req = 1'b0;
    @(posedge clk);
    #1;
    chk_reset("mid-access reset");
    reset_n = 1'b1;
  endtask

  initial begin
    int e0;
    reset_n = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    dm_req = 1'b0;
    dm_we = 1'b0;
    dm_size = '0;
    dm_addr = '0;
    dm_wdata = '0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    reset_n = 1'b1;

    dm_txn(1'b1, SZ_WORD, 17'h10,
           32'hDEAD_BEEF, 32'd0, 1'b0);
    if_txn(17'h10, 32'hDEAD_BEEF, 1'b0);
    dm_txn(1'b1, SZ_WORD, 17'h20,
           32'h1122_3344, 32'd0, 1'b0);
    dm_txn(1'b1, SZ_BYTE, 17'h21,
           32'hFFFF_FFA5, 32'd0, 1'b0);
    dm_txn(1'b0, SZ_HALF, 17'h20,
           32'd0, 32'h0000_A544, 1'b0);
    dm_txn(1'b0, SZ_BYTE, 17'h21,
           32'd0, 32'h0000_00A5, 1'b0);
    dm_txn(1'b0, SZ_WORD, 17'h20,
           32'd0, 32'h1122_A544, 1'b0);

    starve_test();

    e0 = en_cnt;
    dm_txn(1'b0, SZ_WORD, 17'd498,
           32'd0, 32'd0, 1'b1);
    chk("err read enables",
        32'(en_cnt - e0), 32'd0);
    dm_txn(1'b0, SZ_WORD, 17'd497,
           32'd0, 32'hF4F3_F2F1, 1'b0);
    e0 = en_cnt;
    if_txn(17'd498, 32'd0, 1'b1);
    chk("err fetch enables",
        32'(en_cnt - e0), 32'd0);

    reset_in_access();
    dm_txn(1'b0, SZ_WORD, 17'd496,
           32'd0, 32'hCAFE_F00D, 1'b0);

    dm_txn(1'b1, SZ_BYTE, 17'd500,
           32'h0000_007E, 32'd0, 1'b0);
    e0 = en_cnt;
    dm_txn(1'b1, SZ_BYTE, 17'd501,
           32'h0000_0099, 32'd0, 1'b1);
    dm_txn(1'b1, SZ_HALF, 17'd500,
           32'h0000_1234, 32'd0, 1'b1);
    chk("err write enables",
        32'(en_cnt - e0), 32'd0);
    dm_txn(1'b0, SZ_BYTE, 17'd500,
           32'd0, 32'h0000_007E, 1'b0);
    dm_txn(1'b0, SZ_HALF, 17'd499,
           32'd0, 32'h0000_7ECA, 1'b0);

    repeat (3) @(posedge clk);
    chk("final queue drained",
        32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
